// File: rtl/scan_display_pkg.sv
// Shared definitions for the multiplexed value display: read FSM states,
// hex-to-segment glyph table and the all-off segment pattern.
package scan_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } rd_state_t;

  // All segments off (active-low), decimal point off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs, bit7 = dp (always off), bits6..0 = g..a.
  // Element k of the packed array is the glyph for hex digit k.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

// File: rtl/value_scan_display_hex7seg.sv
// Combinational hex digit to active-low seven-segment glyph decoder.
module hex7seg
  import scan_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg_n
);

  assign seg_n = HEX_SEG[value];

endmodule

// File: rtl/value_scan_display.sv
// Multiplexed display of N 4-bit values. Each digit slot lasts SCAN_DIV
// clocks; in the first cycle of a slot the digits are blanked and one value
// is fetched from an external responder into a local buffer.
// Optional feature: define VALUE_SCAN_BLINK_SEL_EN to blink the digit
// selected by sel_valid/sel_idx using a free-running counter's MSB.
//
// Read FSM:
//   state | meaning
//   IDLE  | waiting for the next slot start
//   FETCH | rd_req high, waiting for rd_ack (times out in last slot cycle)
//   DONE  | read finished or abandoned, rest of slot idles
module value_scan_display #(
  parameter int N        = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_W  = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         rd_req,
  output logic [2:0]   rd_idx,
  input  logic         rd_ack,
  input  logic [3:0]   rd_data,
  input  logic         sel_valid,
  input  logic [2:0]   sel_idx,
  output logic [7:0]   seg_n,
  output logic [N-1:0] an_n
);

  import scan_display_pkg::*;

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]      PTR_LAST = 3'(N - 1);

  logic [CNT_W-1:0] cnt;
  logic             slot_start;
  logic             slot_end;
  logic [2:0]       ptr;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             cap_en;

  // Buffer sized for the full 3-bit index space; entries >= N are never written.
  logic [3:0]       vals [8];
  logic [3:0]       cur_val;
  logic [7:0]       glyph;
  logic [N-1:0]     an_scan;

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == CNT_LAST);

  // Slot prescaler: counts 0..SCAN_DIV-1, slot 0 starts right at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Digit pointer advances at each slot end and wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (slot_end) begin
      ptr <= (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: a timed-out fetch lands in DONE exactly at the next slot
  // start, so DONE also launches the next fetch when cnt is 0.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (slot_start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (rd_ack || slot_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (slot_start)    state_nxt = ST_FETCH;
        else if (slot_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request while fetching, capture only on an ack in FETCH.
  always_comb begin
    rd_req = (state == ST_FETCH);
    cap_en = (state == ST_FETCH) && rd_ack;
  end

  // Request index is latched at slot start and held for the whole slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
    end else if (slot_start) begin
      rd_idx <= ptr;
    end
  end

  // Value buffer: written only by an acknowledged fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        vals[i] <= 4'h0;
      end
    end else if (cap_en) begin
      vals[rd_idx] <= rd_data;
    end
  end

  assign cur_val = vals[ptr];

  hex7seg u_hex7seg (
    .value (cur_val),
    .seg_n (glyph)
  );

  // Segments are forced off for as long as reset is held.
  assign seg_n = rst_n ? glyph : SEG_BLANK;

  // Digit enable: blank in slot cycle 0, otherwise only the current digit.
  always_comb begin
    if (slot_start) begin
      an_scan = '1;
    end else begin
      an_scan = ~(N'(1) << ptr);
    end
  end

`ifdef VALUE_SCAN_BLINK_SEL_EN
  localparam logic [3:0] N_L = 4'(N);

  logic [BLINK_W-1:0] blink_cnt;
  logic [N-1:0]       blink_mask;

  // Free-running blink counter; its MSB is the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Blank the selected digit during the MSB-high phase; out-of-range index is ignored.
  always_comb begin
    blink_mask = '0;
    if (sel_valid && blink_cnt[BLINK_W-1] && ({1'b0, sel_idx} < N_L)) begin
      blink_mask = N'(1) << sel_idx;
    end
  end

  assign an_n = an_scan | blink_mask;
`else
  logic unused_sel;
  assign unused_sel = ^{sel_valid, sel_idx};
  assign an_n       = an_scan;
`endif

endmodule

// File: tb/tb_value_scan_display.sv
// Directed, table-driven bench for value_scan_display with N=4, SCAN_DIV=8,
// BLINK_W=4. Builds with or without VALUE_SCAN_BLINK_SEL_EN.
module tb_value_scan_display;

  localparam int N        = 4;
  localparam int SCAN_DIV = 8;
  localparam int BLINK_W  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_req;
  logic [2:0]   rd_idx;
  logic         rd_ack;
  logic [3:0]   rd_data;
  logic         sel_valid;
  logic [2:0]   sel_idx;
  logic [7:0]   seg_n;
  logic [N-1:0] an_n;

  int n_pass  = 0;
  int n_total = 0;
  int tcyc    = 0;   // clock edges since the latest reset release

  always #5 clk = ~clk;

  value_scan_display #(
    .N        (N),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_W  (BLINK_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  typedef struct {
    logic [2:0] idx;      // digit expected for this slot
    int         ack_c;    // slot cycle in which responder acks (0 = never)
    logic [3:0] data;     // value returned on ack
    int         spur_c;   // slot cycle of a spurious ack with data 7 (0 = none)
    logic [7:0] old_seg;  // glyph shown before capture
    logic [7:0] new_seg;  // glyph shown after the slot's fetch
    int         hi;       // cycles rd_req is high in the slot
    logic [2:0] sel_i;    // sel_idx applied during the slot
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [2:0] idx, input int ack_c,
                              input logic [3:0] data, input int spur_c,
                              input logic [7:0] old_seg, input logic [7:0] new_seg,
                              input int hi, input logic [2:0] sel_i);
    vec_t v;
    v.idx = idx; v.ack_c = ack_c; v.data = data; v.spur_c = spur_c;
    v.old_seg = old_seg; v.new_seg = new_seg; v.hi = hi; v.sel_i = sel_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    tcyc++;
  endtask

  // Expected digit enables for a non-blank slot cycle.
  function automatic logic [3:0] exp_an(input logic [2:0] idx);
    logic [3:0] a;
    a = 4'b1111;
    a[idx[1:0]] = 1'b0;
`ifdef VALUE_SCAN_BLINK_SEL_EN
    if (sel_valid && sel_idx < 3'd4 && tcyc[3]) a[sel_idx[1:0]] = 1'b1;
`endif
    return a;
  endfunction

  // Entered at the negedge inside slot cycle 0; leaves at the next slot's cycle 0.
  task automatic run_slot(input vec_t v, input int k);
    string tag;
    int    hi;
    tag     = $sformatf("slot%0d", k);
    rd_ack  = 1'b0;
    rd_data = 4'h7;
    sel_idx = v.sel_i;
    #1;
    check({tag, " blank an_n"}, an_n, 4'hF);
    check({tag, " cycle0 rd_req"}, rd_req, 1'b0);
    check({tag, " old seg_n"}, seg_n, v.old_seg);
    hi = 0;
    for (int c = 1; c < SCAN_DIV; c++) begin
      tick();
      rd_ack  = (c == v.ack_c) || (c == v.spur_c);
      rd_data = (c == v.ack_c) ? v.data : 4'h7;
      #1;
      if (rd_req) hi++;
      if (c == 1) begin
        check({tag, " rd_req"}, rd_req, 1'b1);
        check({tag, " rd_idx"}, rd_idx, v.idx);
      end
      check($sformatf("%s c%0d an_n", tag, c), an_n, exp_an(v.idx));
      if (c == v.ack_c) check({tag, " pre-capture seg_n"}, seg_n, v.old_seg);
      if (v.ack_c > 0 && c == v.ack_c + 1) check({tag, " post-capture seg_n"}, seg_n, v.new_seg);
    end
    check({tag, " rd_req high cycles"}, hi, v.hi);
    check({tag, " final seg_n"}, seg_n, v.new_seg);
    tick();
  endtask

  initial begin
    // idx ack data spur old    new    hi sel
    vecs[0]  = mk(3'd0, 2, 4'h3, 0, 8'hC0, 8'hB0, 2, 3'd1);
    vecs[1]  = mk(3'd1, 2, 4'hA, 0, 8'hC0, 8'h88, 2, 3'd1);
    vecs[2]  = mk(3'd2, 2, 4'h0, 0, 8'hC0, 8'hC0, 2, 3'd1);
    vecs[3]  = mk(3'd3, 2, 4'hF, 0, 8'hC0, 8'h8E, 2, 3'd1);
    vecs[4]  = mk(3'd0, 2, 4'h3, 5, 8'hB0, 8'hB0, 2, 3'd1);  // wrap + spurious ack
    vecs[5]  = mk(3'd1, 4, 4'h5, 0, 8'h88, 8'h92, 4, 3'd1);
    vecs[6]  = mk(3'd2, 0, 4'h0, 0, 8'hC0, 8'hC0, 7, 3'd1);  // timeout
    vecs[7]  = mk(3'd3, 7, 4'h9, 0, 8'h8E, 8'h8E, 7, 3'd1);  // ack in last cycle
    vecs[8]  = mk(3'd0, 2, 4'h1, 0, 8'hB0, 8'hF9, 2, 3'd1);
    vecs[9]  = mk(3'd1, 2, 4'h6, 0, 8'h92, 8'h82, 2, 3'd1);
    vecs[10] = mk(3'd2, 3, 4'hC, 0, 8'hC0, 8'hC6, 3, 3'd1);
    vecs[11] = mk(3'd3, 0, 4'h0, 0, 8'h90, 8'h90, 7, 3'd1);  // last-cycle capture kept
    vecs[12] = mk(3'd0, 2, 4'h2, 0, 8'hF9, 8'hA4, 2, 3'd1);
    vecs[13] = mk(3'd0, 0, 4'h0, 0, 8'hC0, 8'hC0, 7, 3'd5);  // after mid-fetch reset
    vecs[14] = mk(3'd1, 0, 4'h0, 0, 8'hC0, 8'hC0, 7, 3'd5);
    vecs[15] = mk(3'd2, 0, 4'h0, 0, 8'hC0, 8'hC0, 7, 3'd5);
    vecs[16] = mk(3'd3, 0, 4'h0, 0, 8'hC0, 8'hC0, 7, 3'd5);

    rst_n     = 1'b0;
    rd_ack    = 1'b0;
    rd_data   = 4'h7;
    sel_valid = 1'b1;
    sel_idx   = 3'd1;
    repeat (3) tick();
    #1;
    check("reset rd_req", rd_req, 1'b0);
    check("reset rd_idx", rd_idx, 3'd0);
    check("reset seg_n", seg_n, 8'hFF);
    check("reset an_n", an_n, 4'hF);
    tick();
    rst_n = 1'b1;
    tcyc  = 0;

    for (int k = 0; k <= 12; k++) run_slot(vecs[k], k);

    // Reset for one cycle while digit 1 is being fetched.
    tick();
    #1;
    check("pre-reset rd_req", rd_req, 1'b1);
    check("pre-reset rd_idx", rd_idx, 3'd1);
    rst_n   = 1'b0;
    rd_ack  = 1'b1;
    rd_data = 4'h7;
    #1;
    check("mid-fetch reset rd_req", rd_req, 1'b0);
    check("mid-fetch reset rd_idx", rd_idx, 3'd0);
    check("mid-fetch reset seg_n", seg_n, 8'hFF);
    check("mid-fetch reset an_n", an_n, 4'hF);
    tick();
    rd_ack = 1'b0;
    rst_n  = 1'b1;
    tcyc   = 0;

    for (int k = 13; k <= 16; k++) run_slot(vecs[k], k);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
